fetch_stage_hs: RTL and testbench
=================================

# fetch_stage_hs

Handshaked instruction-fetch stage (pre-IF + IF) for the 5-stage LoongArch pipeline. It generates the next PC, issues reads to the synchronous-read instruction SRAM (1-cycle latency), and holds the fetched {pc, inst} until ID accepts it through a valid/allowin handshake. It absorbs ID stalls without refetching and cancels wrong-path fetches on a taken branch, including branches that resolve while ID is stalled. Its output feeds the IF/ID boundary directly.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, address of the first instruction fetched after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ds_allowin  in  1  ID can accept an instruction this cycle
- br_taken  in  1  branch redirect from ID, single-cycle pulse
- br_target  in  32  redirect target, valid when br_taken=1
- inst_sram_en  out  1  SRAM read request
- inst_sram_we  out  4  always 4'h0
- inst_sram_addr  out  32  request address (nextpc)
- inst_sram_wdata  out  32  always 32'h0
- inst_sram_rdata  in  32  read data, valid the cycle after a request
- fs_to_ds_valid  out  1  {fs_pc, fs_inst} valid toward ID
- fs_pc  out  32  PC of the instruction in IF
- fs_inst  out  32  instruction word in IF

## Operation
- State: fs_valid, fs_pc, br_pending, br_target_buf, buf_valid, inst_buf.
- to_fs_valid = ~reset; fs_ready_go = 1; fs_allowin = ~fs_valid | ds_allowin.
- nextpc priority: br_pending ? br_target_buf : br_taken ? br_target : fs_pc + 4 (modulo 2^32, no carry out).
- inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc.
- Issue (en=1): on edge fs_pc <= nextpc, fs_valid <= 1, br_pending <= 0, buf_valid <= 0.
- No issue and fs_valid & ds_allowin: fs_valid <= 0.
- fs_to_ds_valid = fs_valid & ~br_taken (IF instruction is wrong-path in a redirect cycle; no delay slot).
- br_taken with fs_allowin=0: fs_valid <= 0, br_pending <= 1, br_target_buf <= br_target; redirect issues next cycle.
- br_taken with fs_allowin=1: target issued in same cycle; no pending state.
- br_taken while br_pending=1: new target overwrites br_target_buf.
- Stall buffer: fs_valid & ~ds_allowin & ~buf_valid & ~br_taken: inst_buf <= inst_sram_rdata, buf_valid <= 1. Block does not rely on SRAM output holding.
- fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- buf_valid clears on issue, on cancel, and when fs_valid clears.

## Timing
- Reset values: fs_valid 0, fs_pc RESET_PC-4 (32'h1bfffffc), br_pending 0, br_target_buf 0, buf_valid 0, inst_buf 0. During reset: inst_sram_en 0, fs_to_ds_valid 0.
- First cycle after reset deasserts: en=1, addr=RESET_PC; next cycle fs_to_ds_valid=1, fs_pc=RESET_PC.
- Throughput 1 instr/cycle with ds_allowin=1; fetch-to-output latency 1 cycle.
- Branch penalty: 1 cancelled slot when fs_allowin=1; target appears at fs 1 cycle after br_taken. When fs_allowin=0: target issued 1 cycle after br_taken, visible 2 cycles after.
- Reset mid-stall or mid-redirect: all state returns to reset values on the next edge; pending redirect discarded.
- we/wdata constant zero in all cycles.

## Test plan
- Reset release, ds_allowin=1 -> addr 1c000000,1c000004,1c000008 on consecutive cycles; fs_pc follows one cycle later with fs_to_ds_valid=1.
- Stall ds_allowin=0 for 3 cycles at fs_pc=1c000008, SRAM rdata changed to garbage after first cycle -> inst_sram_en=0, fs_inst holds original word, fs_pc stable; on release next addr 1c00000c.
- br_taken=1, br_target=1c000100 with ds_allowin=1 at fs_pc=1c000010 -> fs_to_ds_valid=0 that cycle, addr=1c000100; next cycle fs_pc=1c000100.
- br_taken to 1c000200 while ds_allowin=0 -> fs_valid drops, en=0 that cycle; next cycle en=1, addr=1c000200; pending cleared.
- Two redirects during stall (1c000300 then 1c000400) -> only 1c000400 fetched.
- Assert reset during a stall with br_pending=1 -> after release first addr is 1c000000, fs_to_ds_valid=0 during reset.

Source files
------------

// File: rtl/fetch_stage_hs.sv
// ---------------------------------------------------------------------------
// fetch_stage_hs
//
// Handshaked instruction-fetch stage (pre-IF + IF) for a 5-stage LoongArch
// pipeline. The pre-IF part computes nextpc and issues a read to a
// synchronous-read instruction SRAM (1-cycle latency). The IF part holds the
// returned {pc, inst} until ID accepts it through a valid/allowin handshake.
//
// ID stalls are absorbed without refetching. Taken branches cancel the
// wrong-path instruction, including branches that resolve while ID stalls.
//
// Ports
//   clk              in   clock, all state updates on the rising edge
//   reset            in   synchronous active-high reset
//   ds_allowin       in   ID can accept an instruction this cycle
//   br_taken         in   branch redirect from ID (single-cycle pulse)
//   br_target        in   redirect target, valid with br_taken
//   inst_sram_en     out  SRAM read request
//   inst_sram_we     out  byte write enables, always zero
//   inst_sram_addr   out  request address (nextpc)
//   inst_sram_wdata  out  write data, always zero
//   inst_sram_rdata  in   read data, valid the cycle after a request
//   fs_to_ds_valid   out  {fs_pc, fs_inst} valid toward ID
//   fs_pc            out  PC of the instruction held in IF
//   fs_inst          out  instruction word held in IF
// ---------------------------------------------------------------------------
module fetch_stage_hs #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    // IF stage state
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    // redirect that could not be issued in the cycle it arrived
    logic        r_br_pending;
    logic [31:0] r_br_target_buf;
    // copy of the SRAM word taken on the first stalled cycle, so the SRAM
    // output is free to change while ID is stalled
    logic        r_buf_valid;
    logic [31:0] r_inst_buf;

    logic        w_to_fs_valid;
    logic        w_fs_ready_go;
    logic        w_fs_allowin;
    logic        w_issue;
    logic [31:0] w_seq_pc;
    logic [31:0] w_nextpc;
    logic        w_defer_redirect;

    assign w_to_fs_valid = ~reset;
    assign w_fs_ready_go = 1'b1;
    assign w_fs_allowin  = ~r_fs_valid | (w_fs_ready_go & ds_allowin);
    assign w_issue       = w_to_fs_valid & w_fs_allowin;

    // sequential PC wraps modulo 2^32
    assign w_seq_pc = r_fs_pc + 32'd4;
    assign w_nextpc = r_br_pending ? r_br_target_buf :
                      br_taken     ? br_target       :
                                     w_seq_pc;

    // A redirect is parked in the target buffer when it cannot be issued
    // this cycle (IF is full and ID is stalled), or when an older redirect
    // is already pending: the pending target owns nextpc this cycle, so the
    // read issued now is wrong-path and the newer target must win.
    assign w_defer_redirect = br_taken & (~w_fs_allowin | r_br_pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid      <= 1'b0;
            r_fs_pc         <= RESET_PC - 32'd4;
            r_br_pending    <= 1'b0;
            r_br_target_buf <= 32'h0;
            r_buf_valid     <= 1'b0;
            r_inst_buf      <= 32'h0;
        end else if (w_defer_redirect) begin
            r_fs_valid      <= 1'b0;
            r_br_pending    <= 1'b1;
            r_br_target_buf <= br_target;
            r_buf_valid     <= 1'b0;
        end else if (w_issue) begin
            r_fs_pc      <= w_nextpc;
            r_fs_valid   <= 1'b1;
            r_br_pending <= 1'b0;
            r_buf_valid  <= 1'b0;
        end else if (r_fs_valid && ds_allowin) begin
            r_fs_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else if (r_fs_valid && !ds_allowin && !r_buf_valid && !br_taken) begin
            // first stalled cycle: the SRAM still shows the word for fs_pc
            r_inst_buf  <= inst_sram_rdata;
            r_buf_valid <= 1'b1;
        end
    end

    assign inst_sram_en    = w_issue;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = 32'h0;

    // The instruction in IF is wrong-path whenever ID redirects (no delay
    // slot); reset also masks it so ID never sees a stale instruction.
    assign fs_to_ds_valid = r_fs_valid & ~br_taken & ~reset;
    assign fs_pc          = r_fs_pc;
    assign fs_inst        = r_buf_valid ? r_inst_buf : inst_sram_rdata;

endmodule

// File: tb/tb_fetch_stage_hs.sv
module tb_fetch_stage_hs;

    logic        clk;
    logic        reset;
    logic        ds_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    logic        garbage;
    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];

    fetch_stage_hs #(.RESET_PC(32'h1c000000)) dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ~a ^ 32'h0f0f_0000;
    endfunction

    // synchronous-read SRAM; output turns to garbage on idle cycles when asked
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_of(inst_sram_addr);
        else if (garbage)
            inst_sram_rdata <= 32'hdeadbeef;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: pop on every ID handshake
    task automatic sb_check();
        logic [31:0] e;
        if (fs_to_ds_valid && ds_allowin) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h expected none", fs_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", fs_pc, e);
                chk("sb_inst", fs_inst, inst_of(e));
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ds;
        logic        br;
        logic [31:0] tgt;
        logic        garb;
        logic        exp_en;
        logic        chk_addr;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[25];

    initial begin
        logic [31:0] next_pc;
        int          hs;

        n_tests = 0;
        n_fail  = 0;
        //            rst  ds   br   tgt           garb en   chka addr          valid pc
        vecs[0]  = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h1bfffffc};
        vecs[1]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000000,1'b0,32'h1bfffffc};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000004,1'b1,32'h1c000000};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000008,1'b1,32'h1c000004};
        vecs[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b1,32'h1c000008};
        vecs[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b1,32'h1c000008};
        vecs[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b1,32'h1c000008};
        vecs[7]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c00000c,1'b1,32'h1c000008};
        vecs[8]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000010,1'b1,32'h1c00000c};
        vecs[9]  = '{1'b0,1'b1,1'b1,32'h1c000100,1'b0,1'b1,1'b1,32'h1c000100,1'b0,32'h1c000010};
        vecs[10] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000104,1'b1,32'h1c000100};
        vecs[11] = '{1'b0,1'b0,1'b1,32'h1c000200,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h1c000104};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000200,1'b0,32'h1c000104};
        vecs[13] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000204,1'b1,32'h1c000200};
        vecs[14] = '{1'b0,1'b0,1'b1,32'h1c000300,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h1c000204};
        vecs[15] = '{1'b0,1'b0,1'b1,32'h1c000400,1'b0,1'b1,1'b0,32'h0,        1'b0,32'h1c000204};
        vecs[16] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000400,1'b0,32'h1c000204};
        vecs[17] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000404,1'b1,32'h1c000400};
        vecs[18] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'h1c000404};
        vecs[19] = '{1'b0,1'b0,1'b1,32'h1c000500,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h1c000404};
        vecs[20] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h1c000404};
        vecs[21] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,32'h1bfffffc};
        vecs[22] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000000,1'b0,32'h1bfffffc};
        vecs[23] = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b1,32'h1c000004,1'b1,32'h1c000000};
        vecs[24] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,32'h1c000004};

        reset      = 1'b1;
        ds_allowin = 1'b1;
        br_taken   = 1'b0;
        br_target  = 32'h0;
        garbage    = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            ds_allowin = vecs[i].ds;
            br_taken   = vecs[i].br;
            br_target  = vecs[i].tgt;
            garbage    = vecs[i].garb;
            if (vecs[i].exp_valid && vecs[i].ds)
                exp_q.push_back(vecs[i].exp_pc);
            #4;
            $display("[TB] vec %0d rst=%b ds=%b br=%b en=%b addr=%h valid=%b pc=%h inst=%h",
                     i, reset, ds_allowin, br_taken, inst_sram_en, inst_sram_addr,
                     fs_to_ds_valid, fs_pc, fs_inst);
            chk("en", {31'h0, inst_sram_en}, {31'h0, vecs[i].exp_en});
            if (vecs[i].chk_addr)
                chk("addr", inst_sram_addr, vecs[i].exp_addr);
            chk("valid", {31'h0, fs_to_ds_valid}, {31'h0, vecs[i].exp_valid});
            chk("pc", fs_pc, vecs[i].exp_pc);
            if (vecs[i].exp_valid)
                chk("inst", fs_inst, inst_of(vecs[i].exp_pc));
            chk("we", {28'h0, inst_sram_we}, 32'h0);
            chk("wdata", inst_sram_wdata, 32'h0);
            sb_check();
        end
        chk("sb_drained", exp_q.size(), 32'd0);

        // random ID back-pressure with an SRAM that turns to garbage when idle:
        // accepted PCs must stay strictly sequential with matching words
        next_pc = 32'h1c000004;
        hs      = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            reset      = 1'b0;
            br_taken   = 1'b0;
            garbage    = 1'b1;
            ds_allowin = 1'($urandom_range(0, 1));
            #4;
            if (fs_to_ds_valid && ds_allowin) begin
                $display("[TB] rand %0d accept pc=%h inst=%h", c, fs_pc, fs_inst);
                chk("rand_pc", fs_pc, next_pc);
                chk("rand_inst", fs_inst, inst_of(next_pc));
                next_pc = next_pc + 32'd4;
                hs++;
            end else begin
                $display("[TB] rand %0d hold pc=%h valid=%b", c, fs_pc, fs_to_ds_valid);
                chk("rand_en_stall", {31'h0, inst_sram_en}, {31'h0, ~fs_to_ds_valid});
            end
        end
        chk("rand_progress", {31'h0, hs > 0}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
